// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//
// Instruction fetch unit with a direct-mapped, one-word-per-line instruction
// cache. Hits are pushed into the instruction queue one cycle after lookup.
// Misses issue a single 4-byte request to the memory controller, fill the
// line when it returns, and then replay the lookup as a hit.
//
// Parameters:
//   ENTRY_W  - index width; the cache holds 2^ENTRY_W one-word lines
//   RESET_PC - PC loaded on reset
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   rdy         in   global enable; when low every register holds
//   iJP_en      in   redirect request (one-cycle pulse)
//   iJP_pc      in   redirect target
//   iIQ_full    in   instruction queue cannot accept a push this cycle
//   oIQ_en      out  push strobe (registered, one cycle per instruction)
//   oIQ_inst    out  pushed instruction word (registered, held when idle)
//   oIQ_pc      out  PC of oIQ_inst (registered, held when idle)
//   oMC_en      out  fetch request to the memory controller (combinational)
//   oMC_addr    out  fetch address (the registered miss PC)
//   iMC_done    in   one-cycle pulse, iMC_inst is valid
//   iMC_inst    in   fetched little-endian word
//   o_dbg_state out  FSM state (0 = IDLE, 1 = MISS)
//   o_dbg_pc    out  current fetch PC
//
// Handshakes:
//   Memory side: oMC_en stays high with oMC_addr stable for the whole request
//   until the cycle iMC_done pulses; that cycle oMC_en drops combinationally
//   and the line is written on the same edge. Queue side: a push happens on
//   the edge where the fetcher presents a hit and iIQ_full is low; the pushed
//   word appears on oIQ_inst/oIQ_pc with oIQ_en high for exactly one cycle.
// ---------------------------------------------------------------------------
module inst_fetcher #(
    parameter int          ENTRY_W  = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        iJP_en,
    input  logic [31:0] iJP_pc,
    input  logic        iIQ_full,
    output logic        oIQ_en,
    output logic [31:0] oIQ_inst,
    output logic [31:0] oIQ_pc,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst,
    output logic        o_dbg_state,
    output logic [31:0] o_dbg_pc
);

    localparam int LINES = 1 << ENTRY_W;
    localparam int TAG_W = 30 - ENTRY_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    // FSM and control registers
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_miss_pc;
    logic [31:0] w_miss_pc_nxt;
    logic        r_jp_pend;
    logic        w_jp_pend_nxt;
    logic [31:0] r_jp_target;
    logic [31:0] w_jp_target_nxt;

    // Instruction queue output registers
    logic        r_iq_en;
    logic        w_iq_en_nxt;
    logic [31:0] r_iq_inst;
    logic [31:0] w_iq_inst_nxt;
    logic [31:0] r_iq_pc;
    logic [31:0] w_iq_pc_nxt;

    // Cache storage
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Lookup and fill addressing
    logic [ENTRY_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [ENTRY_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_fill;

    assign w_idx      = r_pc[ENTRY_W+1:2];
    assign w_tag      = r_pc[31:ENTRY_W+2];
    assign w_fill_idx = r_miss_pc[ENTRY_W+1:2];
    assign w_fill_tag = r_miss_pc[31:ENTRY_W+2];

    // Lookup is always against the current PC; in MISS the result is ignored.
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_miss_pc_nxt   = r_miss_pc;
        w_jp_pend_nxt   = r_jp_pend;
        w_jp_target_nxt = r_jp_target;
        w_iq_en_nxt     = 1'b0;
        w_iq_inst_nxt   = r_iq_inst;
        w_iq_pc_nxt     = r_iq_pc;
        w_fill          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (iJP_en) begin
                    w_pc_nxt = iJP_pc;
                end else if (w_hit) begin
                    // A hit with the queue full simply stalls on the same PC.
                    if (!iIQ_full) begin
                        w_iq_en_nxt   = 1'b1;
                        w_iq_inst_nxt = r_data[w_idx];
                        w_iq_pc_nxt   = r_pc;
                        w_pc_nxt      = r_pc + 32'd4;
                    end
                end else begin
                    // Misses are taken even while the queue is full so the
                    // fill overlaps the back-pressure stall.
                    w_miss_pc_nxt = r_pc;
                    w_state_nxt   = ST_MISS;
                end
            end

            ST_MISS: begin
                // The outstanding request is never cancelled; a redirect is
                // remembered (latest one wins) and applied when it returns.
                if (iJP_en) begin
                    w_jp_pend_nxt   = 1'b1;
                    w_jp_target_nxt = iJP_pc;
                end
                if (iMC_done) begin
                    w_fill        = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_jp_pend_nxt = 1'b0;
                    if (iJP_en) begin
                        w_pc_nxt = iJP_pc;
                    end else if (r_jp_pend) begin
                        w_pc_nxt = r_jp_target;
                    end
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Control, output and valid-bit registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_miss_pc   <= 32'd0;
            r_jp_pend   <= 1'b0;
            r_jp_target <= 32'd0;
            r_iq_en     <= 1'b0;
            r_iq_inst   <= 32'd0;
            r_iq_pc     <= 32'd0;
            r_valid     <= '0;
        end else if (rdy) begin
            r_pc        <= w_pc_nxt;
            r_miss_pc   <= w_miss_pc_nxt;
            r_jp_pend   <= w_jp_pend_nxt;
            r_jp_target <= w_jp_target_nxt;
            r_iq_en     <= w_iq_en_nxt;
            r_iq_inst   <= w_iq_inst_nxt;
            r_iq_pc     <= w_iq_pc_nxt;
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset so they can map onto RAM; the valid
    // bits alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (!rst && rdy && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iMC_inst;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The request drops in the done cycle so the controller sees exactly one
    // completion per request.
    assign oMC_en      = (r_state == ST_MISS) && !iMC_done;
    assign oMC_addr    = r_miss_pc;
    assign oIQ_en      = r_iq_en;
    assign oIQ_inst    = r_iq_inst;
    assign oIQ_pc      = r_iq_pc;
    assign o_dbg_state = r_state;
    assign o_dbg_pc    = r_pc;

endmodule
